// File: rtl/iommu_iotlb.sv
// ---------------------------------------------------------------------------
// iommu_iotlb
//
// Fully associative Sv39 IOTLB for the IOMMU translation path. Leaf
// translations from the page-table walker are cached here and served to
// device-side lookups with a one-cycle registered result.
//
// Parameters:
//   N_ENTRIES  number of entries (power of two, >= 2)
//   PSCID_W    process-context tag width
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   lookup_*_i            lookup request: valid, VPN[26:0], PSCID
//   lookup_*_o            result one cycle later: valid, hit, merged PPN,
//                         {U,X,W,R} permissions (PPN/perm are 0 on a miss)
//   update_*_i            fill from the PTW: VPN, PSCID, PPN, size
//                         (0=4K, 1=2M, 2=1G, 3 ignored), {U,X,W,R}
//   flush_*_i             invalidate, optionally filtered by VPN and/or PSCID
//
// Optional feature (macro IOMMU_IOTLB_PERF_CNT_EN):
//   hit_cnt_o, miss_cnt_o 32-bit saturating counters of completed lookups.
// ---------------------------------------------------------------------------
module iommu_iotlb #(
  parameter int unsigned N_ENTRIES = 16,
  parameter int unsigned PSCID_W   = 20
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               lookup_valid_i,
  input  logic [26:0]        lookup_vpn_i,
  input  logic [PSCID_W-1:0] lookup_pscid_i,
  output logic               lookup_valid_o,
  output logic               lookup_hit_o,
  output logic [43:0]        lookup_ppn_o,
  output logic [3:0]         lookup_perm_o,
  input  logic               update_valid_i,
  input  logic [26:0]        update_vpn_i,
  input  logic [PSCID_W-1:0] update_pscid_i,
  input  logic [43:0]        update_ppn_i,
  input  logic [1:0]         update_size_i,
  input  logic [3:0]         update_perm_i,
  input  logic               flush_i,
  input  logic               flush_vpn_en_i,
  input  logic [26:0]        flush_vpn_i,
  input  logic               flush_pscid_en_i,
  input  logic [PSCID_W-1:0] flush_pscid_i
`ifdef IOMMU_IOTLB_PERF_CNT_EN
  ,
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o
`endif
);

  localparam int IDX_W  = $clog2(N_ENTRIES);
  localparam int TREE_W = N_ENTRIES - 1;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [TREE_W-1:0] tree_t;

  // Entry storage. Only the valid bits need a reset value; the payload is
  // never observed while its valid bit is clear.
  logic [N_ENTRIES-1:0] valid_q;
  logic [26:0]          vpn_q   [N_ENTRIES];
  logic [PSCID_W-1:0]   pscid_q [N_ENTRIES];
  logic [43:0]          ppn_q   [N_ENTRIES];
  logic [1:0]           size_q  [N_ENTRIES];
  logic [3:0]           perm_q  [N_ENTRIES];

  tree_t plru_q;
  tree_t plru_d;

  logic [N_ENTRIES-1:0] lookup_match;
  logic [N_ENTRIES-1:0] fill_dup;
  logic [N_ENTRIES-1:0] flush_match;

  logic  hit_any;
  idx_t  hit_idx;
  logic  dup_any;
  idx_t  dup_idx;
  logic  inv_any;
  idx_t  inv_idx;
  idx_t  victim_idx;
  idx_t  fill_idx;
  logic  fill_accept;
  logic  lookup_hit;
  logic [43:0] hit_ppn;

  // VPN bits that take part in a compare for a given page size. Superpages
  // ignore the low VPN fields, which instead pass through into the PPN.
  function automatic logic [26:0] size_mask(input logic [1:0] size);
    logic [26:0] mask;
    case (size)
      2'd2:    mask = 27'h7FC0000;
      2'd1:    mask = 27'h7FFFE00;
      default: mask = 27'h7FFFFFF;
    endcase
    return mask;
  endfunction

  // Lowest set bit of a vector (0 if none; callers qualify with |vec).
  function automatic idx_t first_set(input logic [N_ENTRIES-1:0] vec);
    idx_t idx;
    idx = '0;
    for (int e = int'(N_ENTRIES) - 1; e >= 0; e--) begin
      if (vec[e]) idx = idx_t'(e);
    end
    return idx;
  endfunction

  // Tree nodes are heap-ordered (children of n are 2n+1 and 2n+2). A node
  // bit of 0 steers the victim search left, 1 steers it right. Touching an
  // entry points every node on its path away from it.
  function automatic tree_t plru_touch(input tree_t tree, input idx_t idx);
    tree_t t;
    idx_t  path;
    idx_t  node;
    t    = tree;
    path = idx;
    node = '0;
    for (int l = 0; l < IDX_W; l++) begin
      if (path[IDX_W-1]) begin
        t[node] = 1'b0;
        node    = idx_t'(2 * node + 2);
      end else begin
        t[node] = 1'b1;
        node    = idx_t'(2 * node + 1);
      end
      path = idx_t'(path << 1);
    end
    return t;
  endfunction

  function automatic idx_t plru_victim(input tree_t tree);
    idx_t v;
    idx_t node;
    v    = '0;
    node = '0;
    for (int l = 0; l < IDX_W; l++) begin
      if (tree[node]) begin
        v    = idx_t'({v, 1'b1});
        node = idx_t'(2 * node + 2);
      end else begin
        v    = idx_t'({v, 1'b0});
        node = idx_t'(2 * node + 1);
      end
    end
    return v;
  endfunction

  // Per-entry compares for the three concurrent users of the array:
  // lookup (entry's own size mask), fill dedupe (same size, fill's mask)
  // and flush filters (entry's own size mask for the VPN filter).
  always_comb begin
    for (int e = 0; e < int'(N_ENTRIES); e++) begin
      lookup_match[e] = valid_q[e]
                     && (pscid_q[e] == lookup_pscid_i)
                     && (((vpn_q[e] ^ lookup_vpn_i) & size_mask(size_q[e])) == 27'd0);
      fill_dup[e]     = valid_q[e]
                     && (pscid_q[e] == update_pscid_i)
                     && (size_q[e] == update_size_i)
                     && (((vpn_q[e] ^ update_vpn_i) & size_mask(update_size_i)) == 27'd0);
      flush_match[e]  = valid_q[e]
                     && (!flush_vpn_en_i
                         || (((vpn_q[e] ^ flush_vpn_i) & size_mask(size_q[e])) == 27'd0))
                     && (!flush_pscid_en_i || (pscid_q[e] == flush_pscid_i));
    end
  end

  // Slot selection. Fill reuses a matching entry first so no duplicates
  // can form, then the lowest free slot, then the pseudo-LRU victim.
  always_comb begin
    hit_any     = |lookup_match;
    hit_idx     = first_set(lookup_match);
    dup_any     = |fill_dup;
    dup_idx     = first_set(fill_dup);
    inv_any     = ~&valid_q;
    inv_idx     = first_set(~valid_q);
    victim_idx  = plru_victim(plru_q);
    fill_accept = update_valid_i && (update_size_i != 2'd3) && !flush_i;
    lookup_hit  = lookup_valid_i && hit_any;
    if (dup_any) begin
      fill_idx = dup_idx;
    end else if (inv_any) begin
      fill_idx = inv_idx;
    end else begin
      fill_idx = victim_idx;
    end
  end

  // Superpage hits splice the untranslated low VPN fields into the PPN.
  always_comb begin
    hit_ppn = ppn_q[hit_idx];
    case (size_q[hit_idx])
      2'd2:    hit_ppn = {ppn_q[hit_idx][43:18], lookup_vpn_i[17:0]};
      2'd1:    hit_ppn = {ppn_q[hit_idx][43:9],  lookup_vpn_i[8:0]};
      default: hit_ppn = ppn_q[hit_idx];
    endcase
  end

  // Recency update: the hit is applied first so that a same-cycle fill
  // ends up as the most recently used entry.
  always_comb begin
    plru_d = plru_q;
    if (lookup_hit) begin
      plru_d = plru_touch(plru_d, hit_idx);
    end
    if (fill_accept) begin
      plru_d = plru_touch(plru_d, fill_idx);
    end
  end

  // Array state. A flush wins over a fill in the same cycle; the fill is
  // dropped rather than deferred.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      plru_q  <= '0;
    end else begin
      plru_q <= plru_d;
      if (flush_i) begin
        valid_q <= valid_q & ~flush_match;
      end else if (fill_accept) begin
        valid_q[fill_idx] <= 1'b1;
        vpn_q[fill_idx]   <= update_vpn_i;
        pscid_q[fill_idx] <= update_pscid_i;
        ppn_q[fill_idx]   <= update_ppn_i;
        size_q[fill_idx]  <= update_size_i;
        perm_q[fill_idx]  <= update_perm_i;
      end
    end
  end

  // Registered lookup result; PPN and permissions read as zero on a miss.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lookup_valid_o <= 1'b0;
      lookup_hit_o   <= 1'b0;
      lookup_ppn_o   <= '0;
      lookup_perm_o  <= '0;
    end else begin
      lookup_valid_o <= lookup_valid_i;
      lookup_hit_o   <= lookup_hit;
      lookup_ppn_o   <= lookup_hit ? hit_ppn : 44'd0;
      lookup_perm_o  <= lookup_hit ? perm_q[hit_idx] : 4'd0;
    end
  end

`ifdef IOMMU_IOTLB_PERF_CNT_EN
  // Counters advance together with the result register, so they already
  // include a lookup in the cycle its result is presented.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (lookup_valid_i) begin
      if (hit_any) begin
        if (hit_cnt_o != 32'hFFFF_FFFF) hit_cnt_o <= hit_cnt_o + 32'd1;
      end else begin
        if (miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_iommu_iotlb.sv
module tb_iommu_iotlb;

  localparam int N  = 16;
  localparam int PW = 20;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          lookup_valid_i;
  logic [26:0]   lookup_vpn_i;
  logic [PW-1:0] lookup_pscid_i;
  logic          lookup_valid_o;
  logic          lookup_hit_o;
  logic [43:0]   lookup_ppn_o;
  logic [3:0]    lookup_perm_o;
  logic          update_valid_i;
  logic [26:0]   update_vpn_i;
  logic [PW-1:0] update_pscid_i;
  logic [43:0]   update_ppn_i;
  logic [1:0]    update_size_i;
  logic [3:0]    update_perm_i;
  logic          flush_i;
  logic          flush_vpn_en_i;
  logic [26:0]   flush_vpn_i;
  logic          flush_pscid_en_i;
  logic [PW-1:0] flush_pscid_i;
`ifdef IOMMU_IOTLB_PERF_CNT_EN
  logic [31:0]   hit_cnt_o;
  logic [31:0]   miss_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  iommu_iotlb #(.N_ENTRIES(N), .PSCID_W(PW)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .lookup_valid_i   (lookup_valid_i),
    .lookup_vpn_i     (lookup_vpn_i),
    .lookup_pscid_i   (lookup_pscid_i),
    .lookup_valid_o   (lookup_valid_o),
    .lookup_hit_o     (lookup_hit_o),
    .lookup_ppn_o     (lookup_ppn_o),
    .lookup_perm_o    (lookup_perm_o),
    .update_valid_i   (update_valid_i),
    .update_vpn_i     (update_vpn_i),
    .update_pscid_i   (update_pscid_i),
    .update_ppn_i     (update_ppn_i),
    .update_size_i    (update_size_i),
    .update_perm_i    (update_perm_i),
    .flush_i          (flush_i),
    .flush_vpn_en_i   (flush_vpn_en_i),
    .flush_vpn_i      (flush_vpn_i),
    .flush_pscid_en_i (flush_pscid_en_i),
    .flush_pscid_i    (flush_pscid_i)
`ifdef IOMMU_IOTLB_PERF_CNT_EN
    ,
    .hit_cnt_o        (hit_cnt_o),
    .miss_cnt_o       (miss_cnt_o)
`endif
  );

  typedef struct {
    logic          lv;
    logic [26:0]   lvpn;
    logic [PW-1:0] lpscid;
    logic          uv;
    logic [26:0]   uvpn;
    logic [PW-1:0] upscid;
    logic [43:0]   uppn;
    logic [1:0]    usize;
    logic [3:0]    uperm;
    logic          fv;
    logic          fve;
    logic [26:0]   fvpn;
    logic          fpe;
    logic [PW-1:0] fpscid;
    logic          chk;
    logic          ehit;
    logic [43:0]   eppn;
    logic [3:0]    eperm;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain set of slots, allocated lowest-free-first,
  // with page matching done by shifting away the untranslated VPN fields.
  logic          m_valid [N];
  logic [26:0]   m_vpn   [N];
  logic [PW-1:0] m_pscid [N];
  logic [43:0]   m_ppn   [N];
  logic [1:0]    m_size  [N];
  logic [3:0]    m_perm  [N];

  logic        m_hit;
  logic [43:0] m_ppn_out;
  logic [3:0]  m_perm_out;

  vec_t tbl[$];

  function automatic int pageShift(input logic [1:0] size);
    return 9 * int'(size);
  endfunction

  function automatic bit samePage(input logic [26:0] a, input logic [26:0] b,
                                  input logic [1:0] size);
    return (a >> pageShift(size)) == (b >> pageShift(size));
  endfunction

  task automatic modelClear();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
  endtask

  task automatic modelLookup(input logic [26:0] vpn, input logic [PW-1:0] pscid);
    int sh;
    m_hit      = 1'b0;
    m_ppn_out  = '0;
    m_perm_out = '0;
    for (int i = 0; i < N; i++) begin
      if (!m_hit && m_valid[i] && m_pscid[i] == pscid && samePage(m_vpn[i], vpn, m_size[i])) begin
        sh         = pageShift(m_size[i]);
        m_hit      = 1'b1;
        m_ppn_out  = ((m_ppn[i] >> sh) << sh) | (44'(vpn) & ((44'd1 << sh) - 44'd1));
        m_perm_out = m_perm[i];
      end
    end
  endtask

  function automatic int modelSlot(input vec_t v);
    int slot;
    slot = -1;
    for (int i = 0; i < N; i++) begin
      if (slot < 0 && m_valid[i] && m_pscid[i] == v.upscid && m_size[i] == v.usize
          && samePage(m_vpn[i], v.uvpn, v.usize)) slot = i;
    end
    for (int i = 0; i < N; i++) begin
      if (slot < 0 && !m_valid[i]) slot = i;
    end
    return slot;
  endfunction

  task automatic modelUpdate(input vec_t v);
    int slot;
    if (v.fv) begin
      for (int i = 0; i < N; i++) begin
        if (m_valid[i] && (!v.fve || samePage(m_vpn[i], v.fvpn, m_size[i]))
            && (!v.fpe || m_pscid[i] == v.fpscid)) m_valid[i] = 1'b0;
      end
    end else if (v.uv && v.usize != 2'd3) begin
      slot = modelSlot(v);
      if (slot >= 0) begin
        m_valid[slot] = 1'b1;
        m_vpn[slot]   = v.uvpn;
        m_pscid[slot] = v.upscid;
        m_ppn[slot]   = v.uppn;
        m_size[slot]  = v.usize;
        m_perm[slot]  = v.uperm;
      end
    end
  endtask

  function automatic vec_t idleVec();
    vec_t v;
    v.lv = 0; v.lvpn = '0; v.lpscid = '0;
    v.uv = 0; v.uvpn = '0; v.upscid = '0; v.uppn = '0; v.usize = '0; v.uperm = '0;
    v.fv = 0; v.fve = 0; v.fvpn = '0; v.fpe = 0; v.fpscid = '0;
    v.chk = 0; v.ehit = 0; v.eppn = '0; v.eperm = '0;
    return v;
  endfunction

  function automatic vec_t lookupVec(input logic [26:0] vpn, input logic [PW-1:0] pscid,
                                     input logic ehit, input logic [43:0] eppn,
                                     input logic [3:0] eperm);
    vec_t v;
    v = idleVec();
    v.lv = 1; v.lvpn = vpn; v.lpscid = pscid;
    v.chk = 1; v.ehit = ehit; v.eppn = eppn; v.eperm = eperm;
    return v;
  endfunction

  function automatic vec_t fillVec(input logic [26:0] vpn, input logic [PW-1:0] pscid,
                                   input logic [43:0] ppn, input logic [1:0] size,
                                   input logic [3:0] perm);
    vec_t v;
    v = idleVec();
    v.uv = 1; v.uvpn = vpn; v.upscid = pscid; v.uppn = ppn; v.usize = size; v.uperm = perm;
    return v;
  endfunction

  function automatic vec_t flushVec(input logic ve, input logic [26:0] vpn,
                                    input logic pe, input logic [PW-1:0] pscid);
    vec_t v;
    v = idleVec();
    v.fv = 1; v.fve = ve; v.fvpn = vpn; v.fpe = pe; v.fpscid = pscid;
    return v;
  endfunction

  function automatic logic [26:0] randVpn();
    return {9'($urandom_range(0, 1)), 9'($urandom_range(0, 1)), 9'($urandom_range(0, 3))};
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s #%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, step the model on pre-edge state, then
  // sample just after the edge. Table vectors carry their own expectations;
  // random vectors are judged against the model.
  task automatic applyStimulus(input vec_t v, input bit use_model, input int idx);
    lookup_valid_i   = v.lv;
    lookup_vpn_i     = v.lvpn;
    lookup_pscid_i   = v.lpscid;
    update_valid_i   = v.uv;
    update_vpn_i     = v.uvpn;
    update_pscid_i   = v.upscid;
    update_ppn_i     = v.uppn;
    update_size_i    = v.usize;
    update_perm_i    = v.uperm;
    flush_i          = v.fv;
    flush_vpn_en_i   = v.fve;
    flush_vpn_i      = v.fvpn;
    flush_pscid_en_i = v.fpe;
    flush_pscid_i    = v.fpscid;
    modelLookup(v.lvpn, v.lpscid);
    modelUpdate(v);
    @(posedge clk_i);
    #1;
    checkOutput("valid", idx, 64'(lookup_valid_o), 64'(v.lv));
    if (use_model) begin
      if (v.lv) begin
        checkOutput("rand_hit", idx, 64'(lookup_hit_o), 64'(m_hit));
        checkOutput("rand_ppn", idx, 64'(lookup_ppn_o), 64'(m_ppn_out));
        checkOutput("rand_perm", idx, 64'(lookup_perm_o), 64'(m_perm_out));
      end
    end else if (v.chk) begin
      checkOutput("hit", idx, 64'(lookup_hit_o), 64'(v.ehit));
      checkOutput("ppn", idx, 64'(lookup_ppn_o), 64'(v.eppn));
      checkOutput("perm", idx, 64'(lookup_perm_o), 64'(v.eperm));
    end
  endtask

  initial begin
    vec_t v;
    modelClear();
    applyStimulusIdle();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_valid", 0, 64'(lookup_valid_o), 64'd0);
    checkOutput("rst_hit", 0, 64'(lookup_hit_o), 64'd0);
    checkOutput("rst_ppn", 0, 64'(lookup_ppn_o), 64'd0);
    checkOutput("rst_perm", 0, 64'(lookup_perm_o), 64'd0);
    rst_i = 1'b0;

    // Basic 4K and 1G behaviour.
    tbl.push_back(lookupVec(27'h0001234, 5, 0, 44'h0, 4'h0));
    tbl.push_back(fillVec(27'h0001234, 5, 44'hABCDE, 2'd0, 4'b0011));
    tbl.push_back(lookupVec(27'h0001234, 5, 1, 44'hABCDE, 4'b0011));
    tbl.push_back(lookupVec(27'h0001234, 6, 0, 44'h0, 4'h0));
    tbl.push_back(fillVec(27'h4000000, 5, 44'h80000000, 2'd2, 4'b1011));
    tbl.push_back(lookupVec(27'h4012345, 5, 1, 44'h80012345, 4'b1011));
    tbl.push_back(lookupVec(27'h4412345, 5, 0, 44'h0, 4'h0));
    // Seventeen fills into an empty table: the last evicts the first.
    tbl.push_back(flushVec(0, 27'h0, 0, 0));
    for (int i = 0; i < 17; i++) tbl.push_back(fillVec(27'h100 + 27'(i), 9, 44'h1000 + 44'(i), 2'd0, 4'b0001));
    tbl.push_back(lookupVec(27'h100, 9, 0, 44'h0, 4'h0));
    for (int i = 1; i < 17; i++) tbl.push_back(lookupVec(27'h100 + 27'(i), 9, 1, 44'h1000 + 44'(i), 4'b0001));
    // PSCID-filtered flush, then flush-all.
    tbl.push_back(flushVec(0, 27'h0, 0, 0));
    tbl.push_back(fillVec(27'h200, 5, 44'h2000, 2'd0, 4'b0010));
    tbl.push_back(fillVec(27'h201, 5, 44'h2001, 2'd0, 4'b0010));
    tbl.push_back(fillVec(27'h300, 7, 44'h3000, 2'd0, 4'b0010));
    tbl.push_back(fillVec(27'h301, 7, 44'h3001, 2'd0, 4'b0010));
    tbl.push_back(flushVec(0, 27'h0, 1, 5));
    tbl.push_back(lookupVec(27'h200, 5, 0, 44'h0, 4'h0));
    tbl.push_back(lookupVec(27'h201, 5, 0, 44'h0, 4'h0));
    tbl.push_back(lookupVec(27'h300, 7, 1, 44'h3000, 4'b0010));
    tbl.push_back(lookupVec(27'h301, 7, 1, 44'h3001, 4'b0010));
    tbl.push_back(flushVec(0, 27'h0, 0, 0));
    tbl.push_back(lookupVec(27'h300, 7, 0, 44'h0, 4'h0));
    tbl.push_back(lookupVec(27'h301, 7, 0, 44'h0, 4'h0));
    // 2M merge and a VPN-filtered flush using the entry's own page size.
    tbl.push_back(fillVec(27'h0000400, 3, 44'h55500, 2'd1, 4'b0111));
    tbl.push_back(fillVec(27'h0000601, 3, 44'h66601, 2'd0, 4'b0101));
    tbl.push_back(lookupVec(27'h0000455, 3, 1, 44'h55455, 4'b0111));
    tbl.push_back(lookupVec(27'h0000601, 3, 1, 44'h66601, 4'b0101));
    tbl.push_back(flushVec(1, 27'h00005FF, 0, 0));
    tbl.push_back(lookupVec(27'h0000401, 3, 0, 44'h0, 4'h0));
    tbl.push_back(lookupVec(27'h0000601, 3, 1, 44'h66601, 4'b0101));
    // Illegal size is ignored.
    tbl.push_back(fillVec(27'h700, 3, 44'h777, 2'd3, 4'hF));
    tbl.push_back(lookupVec(27'h700, 3, 0, 44'h0, 4'h0));
    // Flush and fill together: fill dropped.
    tbl.push_back(flushVec(0, 27'h0, 0, 0));
    v = fillVec(27'h10, 5, 44'h1010, 2'd0, 4'b0001);
    v.fv = 1;
    tbl.push_back(v);
    tbl.push_back(lookupVec(27'h10, 5, 0, 44'h0, 4'h0));
    // Lookup and fill together: no bypass.
    v = fillVec(27'h20, 5, 44'h2222, 2'd0, 4'b0101);
    v.lv = 1; v.lvpn = 27'h20; v.lpscid = 5; v.chk = 1; v.ehit = 0; v.eppn = '0; v.eperm = '0;
    tbl.push_back(v);
    tbl.push_back(lookupVec(27'h20, 5, 1, 44'h2222, 4'b0101));
    // Refill of the same page overwrites in place.
    tbl.push_back(fillVec(27'h20, 5, 44'h3333, 2'd0, 4'b0110));
    tbl.push_back(lookupVec(27'h20, 5, 1, 44'h3333, 4'b0110));

    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], 1'b0, i);

    // Reset arriving with a lookup in flight discards the result.
    v = lookupVec(27'h20, 5, 1, 44'h3333, 4'b0110);
    lookup_valid_i = v.lv;
    lookup_vpn_i   = v.lvpn;
    lookup_pscid_i = v.lpscid;
    rst_i          = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("rstmid_valid", 0, 64'(lookup_valid_o), 64'd0);
    checkOutput("rstmid_hit", 0, 64'(lookup_hit_o), 64'd0);
    rst_i = 1'b0;
    modelClear();
    applyStimulus(lookupVec(27'h20, 5, 0, 44'h0, 4'h0), 1'b0, 1000);

    // Randomized traffic against the model; a fill that would need an
    // eviction is turned into a flush-all so the model never guesses PLRU.
    for (int c = 0; c < 800; c++) begin
      v = idleVec();
      v.lv     = ($urandom_range(0, 2) != 0);
      v.lvpn   = randVpn();
      v.lpscid = PW'($urandom_range(1, 2));
      if ($urandom_range(0, 2) == 0) begin
        v.uv     = 1;
        v.uvpn   = randVpn();
        v.upscid = PW'($urandom_range(1, 2));
        v.uppn   = 44'({$urandom, $urandom});
        v.usize  = 2'($urandom_range(0, 3));
        v.uperm  = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 19) == 0) begin
        v.fv     = 1;
        v.fve    = 1'($urandom_range(0, 1));
        v.fvpn   = randVpn();
        v.fpe    = 1'($urandom_range(0, 1));
        v.fpscid = PW'($urandom_range(1, 2));
      end
      if (v.uv && !v.fv && v.usize != 2'd3 && modelSlot(v) < 0) begin
        v.fv = 1; v.fve = 0; v.fpe = 0;
      end
      applyStimulus(v, 1'b1, 2000 + c);
    end

    applyStimulusIdle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic applyStimulusIdle();
    lookup_valid_i   = 1'b0;
    lookup_vpn_i     = '0;
    lookup_pscid_i   = '0;
    update_valid_i   = 1'b0;
    update_vpn_i     = '0;
    update_pscid_i   = '0;
    update_ppn_i     = '0;
    update_size_i    = '0;
    update_perm_i    = '0;
    flush_i          = 1'b0;
    flush_vpn_en_i   = 1'b0;
    flush_vpn_i      = '0;
    flush_pscid_en_i = 1'b0;
    flush_pscid_i    = '0;
  endtask

endmodule
